// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter with a one-frame input buffer.
// A BCLK divider builds a 64-bit frame per sample. bit_tick marks each BCLK
// falling edge and locks the upstream synthesizer's 64-step sequencer.
// Optional build macro I2S_UNDERRUN_ZERO_EN: when defined, an underrun loads
// silence. Otherwise the previous frame repeats.
module i2s_tx #(
    parameter int BCLK_HALF   = 16,
    parameter int SAMPLE_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        clr_status,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        bit_tick,
    output logic        frame_tick,
    output logic        overrun,
    output logic        underrun
);

    localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF - 1);

`ifdef I2S_UNDERRUN_ZERO_EN
    localparam logic UNDERRUN_ZERO = 1'b1;
`else
    localparam logic UNDERRUN_ZERO = 1'b0;
`endif

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       k;          // index of the next falling edge
    logic [31:0]      shifter;    // frame currently on the wire
    logic [31:0]      pending;
    logic             pending_full;

    logic             wrap;
    logic             fall;
    logic             load;
    logic [5:0]       pos;
    logic [63:0]      frame;
    logic             sdata_next;

    // Falling-edge and load strobes; a load happens on the k=0 falling edge.
    always_comb begin
        wrap = (div_cnt == DIV_MAX);
        fall = enable & wrap & bclk;
        load = fall & (k == 6'd0);
    end

    // Serial frame {left, pad, right, pad} MSB first; the bit at edge k is
    // position k-1, which gives the one-BCLK I2S delay after lrck changes.
    always_comb begin
        frame = {shifter[SAMPLE_BITS-1:0], {(32-SAMPLE_BITS){1'b0}},
                 shifter[16+SAMPLE_BITS-1:16], {(32-SAMPLE_BITS){1'b0}}};
        pos        = k - 6'd1;
        sdata_next = frame[~pos];
    end

    // BCLK divider, bit index and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            k          <= 6'd0;
            lrck       <= 1'b0;
            sdata      <= 1'b0;
            bit_tick   <= 1'b0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            k          <= 6'd0;
            lrck       <= 1'b0;
            sdata      <= 1'b0;
            bit_tick   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            bit_tick   <= fall;
            frame_tick <= load;
            if (wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall) begin
                k     <= k + 6'd1;
                lrck  <= k[5];
                sdata <= sdata_next;
            end
        end
    end

    // Input buffer, frame load and sticky status flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (load) begin
                if (pending_full) begin
                    shifter <= pending;
                end else if (UNDERRUN_ZERO) begin
                    shifter <= '0;
                end
            end
            if (in_valid) begin
                pending <= in_data;
            end
            if (in_valid) begin
                pending_full <= 1'b1;
            end else if (load) begin
                pending_full <= 1'b0;
            end
            overrun  <= (in_valid & pending_full & ~load) | (overrun & ~clr_status);
            underrun <= (load & ~pending_full) | (underrun & ~clr_status);
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed test of i2s_tx with BCLK_HALF=2 (4 clks per bit).
module tb_i2s_tx;

    localparam int BH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clr_status;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic        bit_tick;
    logic        frame_tick;
    logic        overrun;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int next_k   = 0;
    int k_obs    = 0;

    i2s_tx #(.BCLK_HALF(BH), .SAMPLE_BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clr_status (clr_status),
        .bclk       (bclk),
        .lrck       (lrck),
        .sdata      (sdata),
        .bit_tick   (bit_tick),
        .frame_tick (frame_tick),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic finish_report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Reference frame as it must appear on the wire.
    function automatic logic [63:0] exp_frame(input logic [31:0] d);
        return {d[15:0], 16'h0000, d[31:16], 16'h0000};
    endfunction

    // Wait for the next bit_tick (sampled on negedges), returning clks waited.
    task automatic fall_wait(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bit_tick && gap < 4*BH + 4);
        if (!bit_tick) begin
            check("fall_timeout", 64'd0, 64'd1);
            finish_report();
        end
        k_obs  = next_k;
        next_k = (next_k + 1) % 64;
    endtask

    task automatic run_to(input int target);
        int g;
        do fall_wait(g); while (k_obs != target);
    endtask

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    // From just after a k=63 fall, strobe in_valid into the k=0 load cycle.
    task automatic sync_load_send(input logic [31:0] d);
        repeat (3) @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("coinc_ticks", {62'd0, bit_tick, frame_tick}, 64'd3);
        k_obs  = 0;
        next_k = 1;
    endtask

    // Capture sdata/lrck for k=1..63 and the following k=0.
    task automatic capture(output logic [63:0] sd, output logic [63:0] lr);
        int g;
        for (int i = 0; i < 64; i++) begin
            fall_wait(g);
            sd[63-i] = sdata;
            lr[63-i] = lrck;
        end
    endtask

    initial begin
        int g, t, bad, ft_cnt, ft_time, lr_rise, ticks;
        logic [63:0] sd, lr;

        rst_n = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; clr_status = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {57'd0, bclk, lrck, sdata, bit_tick, frame_tick, overrun, underrun}, 64'd0);

        // Timebase with no input
        rst_n = 1'b1; enable = 1'b1; next_k = 0;
        fall_wait(g);
        check("first_fall_gap", 64'(g), 64'd4);
        check("first_frame_tick", {63'd0, frame_tick}, 64'd1);
        check("underrun_first", {63'd0, underrun}, 64'd1);
        bad = 0; t = 0; ft_cnt = 0; ft_time = -1; lr_rise = -1;
        for (int i = 1; i <= 64; i++) begin
            fall_wait(g);
            t += g;
            if (g != 4) bad++;
            if (frame_tick) begin ft_cnt++; ft_time = t; end
            if (lrck && lr_rise < 0) lr_rise = t;
        end
        check("tick_gap_errs", 64'(bad), 64'd0);
        check("frame_tick_cnt", 64'(ft_cnt), 64'd1);
        check("frame_period", 64'(ft_time), 64'd256);
        check("lrck_low_time", 64'(lr_rise), 64'd128);
        check("lrck_k0", {63'd0, lrck}, 64'd0);

        // Basic frame
        pulse_clr();
        send(32'h1234_ABCD);
        run_to(0);
        check("t2_no_underrun", {63'd0, underrun}, 64'd0);
        capture(sd, lr);
        check("t2_sdata", sd, exp_frame(32'h1234_ABCD));
        check("t2_lrck", lr, 64'h0000_0001_FFFF_FFFE);
        check("t2_underrun_end", {63'd0, underrun}, 64'd1);

        // Overrun
        pulse_clr();
        send(32'h5555_0000);
        fall_wait(g);
        send(32'hAAAA_0000);
        check("overrun_set", {63'd0, overrun}, 64'd1);
        run_to(0);
        capture(sd, lr);
        check("t3_sdata", sd, exp_frame(32'hAAAA_0000));
        check("overrun_sticky", {63'd0, overrun}, 64'd1);
        pulse_clr();
        check("flags_cleared", {62'd0, overrun, underrun}, 64'd0);

        // Set wins over clear in the same cycle
        send(32'h1111_2222);
        in_data = 32'h3333_4444; in_valid = 1'b1; clr_status = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr_status = 1'b0;
        check("set_wins", {63'd0, overrun}, 64'd1);

        // in_valid coincident with the load
        fall_wait(g);
        pulse_clr();
        run_to(63);
        sync_load_send(32'h5A5A_C3C3);
        capture(sd, lr);
        check("t4_old_pending", sd, exp_frame(32'h3333_4444));
        check("t4_flags", {62'd0, overrun, underrun}, 64'd0);
        capture(sd, lr);
        check("t4_new_frame", sd, exp_frame(32'h5A5A_C3C3));
        check("t4_underrun_end", {63'd0, underrun}, 64'd1);

        // Underrun behaviour
        pulse_clr();
        send(32'h0F0F_F0F0);
        run_to(0);
        capture(sd, lr);
        check("t5_frame", sd, exp_frame(32'h0F0F_F0F0));
        check("t5_underrun", {63'd0, underrun}, 64'd1);
        capture(sd, lr);
`ifdef I2S_UNDERRUN_ZERO_EN
        check("t5_underrun_frame", sd, 64'd0);
`else
        check("t5_underrun_frame", sd, exp_frame(32'h0F0F_F0F0));
`endif
        check("t5_underrun_hold", {63'd0, underrun}, 64'd1);

        // Enable low mid-frame, input accepted while stopped, fresh restart
        run_to(40);
        enable = 1'b0;
        @(negedge clk);
        check("disable_outs", {59'd0, bclk, lrck, sdata, bit_tick, frame_tick}, 64'd0);
        pulse_clr();
        send(32'hC0DE_BEEF);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bit_tick || bclk) ticks++;
        end
        check("disabled_idle", 64'(ticks), 64'd0);
        enable = 1'b1; next_k = 0;
        fall_wait(g);
        check("restart_gap", 64'(g), 64'd4);
        check("restart_frame_tick", {63'd0, frame_tick}, 64'd1);
        check("restart_no_underrun", {63'd0, underrun}, 64'd0);
        capture(sd, lr);
        check("restart_frame", sd, exp_frame(32'hC0DE_BEEF));

        // Asynchronous reset mid-frame
        run_to(40);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {57'd0, bclk, lrck, sdata, bit_tick, frame_tick, overrun, underrun}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; next_k = 0;
        fall_wait(g);
        check("post_reset_gap", 64'(g), 64'd4);
        check("post_reset_frame_tick", {63'd0, frame_tick}, 64'd1);
        check("post_reset_underrun", {63'd0, underrun}, 64'd1);

        finish_report();
    end

endmodule
